// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning channel multiplexer: mode encodings
// and the rotating "next enabled channel" search used for scan targeting.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Upper bound on channel count the search helper can handle.
    localparam int MAX_CH    = 64;
    localparam int MAX_SEL_W = 6;

    typedef struct packed {
        logic                 found;
        logic [MAX_SEL_W-1:0] idx;
        logic                 wrapped;
    } nsi_t;

    // Find the first set bit of mask (n valid bits) walking upward from start
    // and wrapping modulo n. With inclusive=1 the start bit itself is the
    // first candidate; with inclusive=0 the walk begins one above start and
    // ends on start itself, so a lone set bit is found again as a wrap.
    // wrapped flags that the returned index is not above start.
    function automatic nsi_t next_set_idx(
        input logic [MAX_CH-1:0] mask,
        input int                n,
        input int                start,
        input logic              inclusive
    );
        nsi_t r;
        int   first;
        int   last;
        int   j;
        r     = '0;
        first = inclusive ? 0 : 1;
        last  = inclusive ? n - 1 : n;
        for (int off = 0; off <= MAX_CH; off++) begin
            if (!r.found && off >= first && off <= last) begin
                j = start + off;
                if (j >= n) begin
                    j = j - n;
                end
                if (mask[j]) begin
                    r.found   = 1'b1;
                    r.idx     = MAX_SEL_W'(j);
                    r.wrapped = inclusive ? (j < start) : (j <= start);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_sel_rr_next_en.sv
// Combinational rotating-priority finder over a channel enable mask.
module rr_next_en
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int SEL_W     = 3,
    parameter bit INCLUSIVE = 1'b1
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  start,
    output logic              found,
    output logic [SEL_W-1:0]  idx,
    output logic              wrapped
);

    nsi_t res;

    // Search the mask from start and narrow the result to this channel count.
    always_comb begin
        res     = next_set_idx(MAX_CH'(mask), NUM_CH, int'(start), INCLUSIVE);
        found   = res.found && (int'(res.idx) < NUM_CH);
        idx     = SEL_W'(res.idx);
        wrapped = res.wrapped;
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N:1 channel multiplexer with valid/ready output and an
// auto-scan mode that dwells a fixed number of accepted samples per
// enabled channel.
module mux_scan_sel
    import mux_scan_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 1,
    parameter int DWELL  = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] din,
    output logic [DATA_W-1:0]        dout,
    output logic [SEL_W-1:0]         dout_ch,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     wrap
);

    localparam int              CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    // Handshake: a sample sits in dout while dout_valid is high and leaves on
    // a cycle where dout_ready is high. The output slot may be refilled in
    // that same cycle, so full throughput is one sample per clock.

    logic [DATA_W-1:0] dout_q,      dout_d;
    logic [SEL_W-1:0]  dout_ch_q,   dout_ch_d;
    logic              dout_valid_q, dout_valid_d;
    logic              wrap_q,      wrap_d;
    logic [SEL_W-1:0]  cur_ch_q,    cur_ch_d;
    logic [CNT_W-1:0]  dwell_q,     dwell_d;
    logic              wrap_pend_q, wrap_pend_d;
    logic              mode_q,      mode_d;

    logic              slot_free;
    logic              mode_chg;
    logic [CNT_W-1:0]  dwell_eff;
    logic              pend_eff;
    logic [SEL_W-1:0]  tgt;
    logic              tgt_valid;
    logic              capture;
    logic [DATA_W-1:0] sample;

    logic              scan_found;
    logic [SEL_W-1:0]  scan_tgt;
    logic              tgt_wrap_unused;
    logic              adv_found_unused;
    logic [SEL_W-1:0]  adv_idx;
    logic              adv_wrap;

    // Scan target: cur_ch if enabled, else the next enabled channel above it.
    rr_next_en #(
        .NUM_CH    (NUM_CH),
        .SEL_W     (SEL_W),
        .INCLUSIVE (1'b1)
    ) u_tgt (
        .mask    (ch_mask),
        .start   (cur_ch_q),
        .found   (scan_found),
        .idx     (scan_tgt),
        .wrapped (tgt_wrap_unused)
    );

    // Advance point: the next enabled channel strictly after the target.
    rr_next_en #(
        .NUM_CH    (NUM_CH),
        .SEL_W     (SEL_W),
        .INCLUSIVE (1'b0)
    ) u_adv (
        .mask    (ch_mask),
        .start   (scan_tgt),
        .found   (adv_found_unused),
        .idx     (adv_idx),
        .wrapped (adv_wrap)
    );

    // Target selection and capture decision; a mode change zeroes the scan
    // bookkeeping before a same-cycle capture sees it.
    always_comb begin
        slot_free = !dout_valid_q || dout_ready;
        mode_chg  = (mode != mode_q);
        dwell_eff = mode_chg ? '0 : dwell_q;
        pend_eff  = mode_chg ? 1'b0 : wrap_pend_q;
        if (mode == MODE_SCAN) begin
            tgt       = scan_tgt;
            tgt_valid = scan_found;
        end else begin
            tgt       = sel_in;
            tgt_valid = (int'(sel_in) < NUM_CH);
        end
        capture = en && slot_free && tgt_valid;
    end

    // Pick the data slice of the target channel.
    always_comb begin
        sample = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(tgt) == i) begin
                sample = din[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for output register, dwell counter and wrap tracking.
    always_comb begin
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = dout_valid_q;
        wrap_d       = 1'b0;
        cur_ch_d     = cur_ch_q;
        dwell_d      = dwell_eff;
        wrap_pend_d  = pend_eff;
        mode_d       = mode;
        if (capture) begin
            dout_d       = sample;
            dout_ch_d    = tgt;
            dout_valid_d = 1'b1;
            if (pend_eff) begin
                wrap_d      = 1'b1;
                wrap_pend_d = 1'b0;
            end
            if (mode == MODE_SCAN) begin
                if (dwell_eff == DWELL_LAST) begin
                    dwell_d  = '0;
                    cur_ch_d = adv_idx;
                    if (adv_wrap) begin
                        wrap_pend_d = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_eff + 1'b1;
                end
            end
        end else if (slot_free) begin
            dout_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held sample immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
            cur_ch_q     <= '0;
            dwell_q      <= '0;
            wrap_pend_q  <= 1'b0;
            mode_q       <= MODE_MANUAL;
        end else begin
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
            wrap_q       <= wrap_d;
            cur_ch_q     <= cur_ch_d;
            dwell_q      <= dwell_d;
            wrap_pend_q  <= wrap_pend_d;
            mode_q       <= mode_d;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed bench for mux_scan_sel: manual select (8, 12 and 6 channel
// builds), full and sparse scans with dwell and wrap, backpressure, empty
// mask / disable, and asynchronous reset during a stall.
module tb_mux_scan_sel;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT: 8 ch, 4 bit, dwell 2 ----------------
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  sel_in = '0;
    logic [7:0]  ch_mask = '0;
    logic [31:0] din = '0;
    logic [3:0]  dout;
    logic [2:0]  dout_ch;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        wrap;

    mux_scan_sel #(.NUM_CH(8), .DATA_W(4), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .ch_mask(ch_mask), .din(din), .dout(dout), .dout_ch(dout_ch),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .wrap(wrap)
    );

    // ---------------- 12 channel build (SEL_W = 4) ----------------
    logic        en12 = 1'b0;
    logic        mode12 = 1'b0;
    logic [3:0]  sel12 = '0;
    logic [11:0] mask12 = '0;
    logic [47:0] din12 = 48'hBA98_7654_3210;
    logic [3:0]  dout12;
    logic [3:0]  ch12;
    logic        valid12;
    logic        wrap12;

    mux_scan_sel #(.NUM_CH(12), .DATA_W(4), .DWELL(2)) dut12 (
        .clk(clk), .rst(rst), .en(en12), .mode(mode12), .sel_in(sel12),
        .ch_mask(mask12), .din(din12), .dout(dout12), .dout_ch(ch12),
        .dout_valid(valid12), .dout_ready(dout_ready), .wrap(wrap12)
    );

    // ---------------- 6 channel build (SEL_W = 3) ----------------
    logic        en6 = 1'b0;
    logic        mode6 = 1'b0;
    logic [2:0]  sel6 = '0;
    logic [5:0]  mask6 = '0;
    logic [23:0] din6 = 24'h54_3210;
    logic [3:0]  dout6;
    logic [2:0]  ch6;
    logic        valid6;
    logic        wrap6;

    mux_scan_sel #(.NUM_CH(6), .DATA_W(4), .DWELL(2)) dut6 (
        .clk(clk), .rst(rst), .en(en6), .mode(mode6), .sel_in(sel6),
        .ch_mask(mask6), .din(din6), .dout(dout6), .dout_ch(ch6),
        .dout_valid(valid6), .dout_ready(dout_ready), .wrap(wrap6)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the full output set of the main DUT.
    task automatic chk_main(input string tag, input logic v, input logic [3:0] d,
                            input logic [2:0] c, input logic w);
        chk({tag, ".valid"}, 32'(dout_valid), 32'(v));
        chk({tag, ".dout"},  32'(dout),       32'(d));
        chk({tag, ".ch"},    32'(dout_ch),    32'(c));
        chk({tag, ".wrap"},  32'(wrap),       32'(w));
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DIN_SCAN = 32'h8765_4321;  // channel i carries i+1

    logic [2:0] exp_ch;

    // ---------------- directed sequence ----------------
    initial begin
        // Reset state
        #2;
        chk_main("reset", 1'b0, 4'h0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;

        // 1. Manual select
        mode = 1'b0; sel_in = 3'd5; din = 32'h00A0_0000; en = 1'b1; dout_ready = 1'b1;
        tick();
        chk_main("man_ch5", 1'b1, 4'hA, 3'd5, 1'b0);
        en = 1'b0;
        tick();
        chk_main("man_idle", 1'b0, 4'hA, 3'd5, 1'b0);

        en12 = 1'b1; sel12 = 4'd9; en6 = 1'b1; sel6 = 3'd2;
        tick();
        chk("n12_ch9.valid", 32'(valid12), 32'd1);
        chk("n12_ch9.dout",  32'(dout12),  32'h9);
        chk("n12_ch9.ch",    32'(ch12),    32'd9);
        chk("n6_ch2.valid",  32'(valid6),  32'd1);
        chk("n6_ch2.dout",   32'(dout6),   32'h2);
        sel12 = 4'd11; sel6 = 3'd7;
        tick();
        chk("n12_ch11.dout", 32'(dout12),  32'hB);
        chk("n12_ch11.ch",   32'(ch12),    32'd11);
        chk("n6_sel7.valid", 32'(valid6),  32'd0);
        chk("n6_sel7.dout",  32'(dout6),   32'h2);
        chk("n6_sel7.ch",    32'(ch6),     32'd2);
        sel12 = 4'd13;
        tick();
        chk("n12_sel13.valid", 32'(valid12), 32'd0);
        chk("n12_sel13.dout",  32'(dout12),  32'hB);
        en12 = 1'b0; en6 = 1'b0;

        // 2. Full scan, mask FF: each channel twice, wrap on the 17th sample
        mode = 1'b1; ch_mask = 8'hFF; din = DIN_SCAN; en = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_ch = 3'((k - 1) / 2);
            chk_main($sformatf("scan_s%0d", k), 1'b1, 4'(exp_ch) + 4'd1, exp_ch, (k == 17));
        end

        // 4. Backpressure: three stalled cycles hold everything, din ignored
        dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            din = 32'h0;
            tick();
            chk_main($sformatf("stall_%0d", k), 1'b1, 4'h1, 3'd0, 1'b0);
        end
        dout_ready = 1'b1; din = DIN_SCAN;
        tick();
        chk_main("resume_s19", 1'b1, 4'h2, 3'd1, 1'b0);
        tick();
        chk_main("resume_s20", 1'b1, 4'h2, 3'd1, 1'b0);
        tick();
        chk_main("resume_s21", 1'b1, 4'h3, 3'd2, 1'b0);

        // 5a. Disable: valid drops, data and channel hold
        en = 1'b0; mode = 1'b0;
        tick();
        chk_main("en_off", 1'b0, 4'h3, 3'd2, 1'b0);

        // 3. Sparse mask 1010_0100: 2,2,5,5,7,7,2,2 with wrap on the 7th
        mode = 1'b1; ch_mask = 8'b1010_0100; en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            case (k)
                1, 2:    exp_ch = 3'd2;
                3, 4:    exp_ch = 3'd5;
                5, 6:    exp_ch = 3'd7;
                default: exp_ch = 3'd2;
            endcase
            chk_main($sformatf("sparse_s%0d", k), 1'b1, 4'(exp_ch) + 4'd1, exp_ch, (k == 7));
        end

        // 5b. Empty mask: valid drops, data holds
        ch_mask = 8'h00;
        tick();
        chk_main("mask_empty", 1'b0, 4'h3, 3'd2, 1'b0);
        tick();
        chk_main("mask_empty2", 1'b0, 4'h3, 3'd2, 1'b0);

        // 5c. Single channel 4: wrap on every pass after the first
        ch_mask = 8'h10;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_main($sformatf("single_s%0d", k), 1'b1, 4'h5, 3'd4, (k == 3 || k == 5));
        end

        // 6. Reset between edges while stalled
        dout_ready = 1'b0;
        tick();
        chk("prerst.valid", 32'(dout_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_main("rst_async", 1'b0, 4'h0, 3'd0, 1'b0);
        tick();
        chk_main("rst_held", 1'b0, 4'h0, 3'd0, 1'b0);
        rst = 1'b0; dout_ready = 1'b1; ch_mask = 8'hFF;
        tick();
        chk_main("post_rst_s1", 1'b1, 4'h1, 3'd0, 1'b0);
        tick();
        chk_main("post_rst_s2", 1'b1, 4'h1, 3'd0, 1'b0);
        tick();
        chk_main("post_rst_s3", 1'b1, 4'h2, 3'd1, 1'b0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised registered N:1 data multiplexer; the next generation of the team's fixed 8:1 single-bit mux.
- Adds configurable channel count and data width, a registered output with valid/ready handshake, and an auto-scan mode.
- Auto-scan steps through the enabled channels, dwelling a programmable number of accepted samples on each.
- Sits between a bank of sampled sources and a single downstream consumer (logger/serialiser).

Parameters:
- NUM_CH, 8, number of input channels (>=2).
- DATA_W, 1, width of each channel in bits.
- DWELL, 4, accepted samples per channel before advancing in scan mode (>=1).
- SEL_W, $clog2(NUM_CH), width of channel index (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  capture enable.
- mode  input  1  0 = manual select, 1 = auto-scan.
- sel_in  input  SEL_W  channel index in manual mode.
- ch_mask  input  NUM_CH  per-channel enable for scan mode (bit i = channel i).
- din  input  NUM_CH*DATA_W  packed channel data; channel i = din[i*DATA_W +: DATA_W].
- dout  output  DATA_W  registered selected sample.
- dout_ch  output  SEL_W  index of channel in dout.
- dout_valid  output  1  dout/dout_ch hold a sample.
- dout_ready  input  1  consumer accepts sample.
- wrap  output  1  one-cycle flag marking the first sample of a new scan pass.

Behaviour:
- Reset (async, immediate): dout=0, dout_ch=0, dout_valid=0, wrap=0; internal cur_ch=0, dwell_cnt=0, wrap_pend=0. Takes effect mid-transfer; any held sample is discarded.
- Slot free = !dout_valid || dout_ready.
- Capture condition = en && slot free && target valid.
- Target valid, manual mode: sel_in < NUM_CH (ch_mask ignored).
- Target valid, scan mode: ch_mask != 0.
- On capture (1-cycle latency): dout <= din slice of target; dout_ch <= target; dout_valid <= 1.
- Slot free with no capture: dout_valid <= 0. Data and channel registers hold their values.
- Stall (dout_valid && !dout_ready): all outputs and dwell_cnt hold; din changes are ignored.
- Scan target: cur_ch if ch_mask[cur_ch]; otherwise the next set mask bit above cur_ch, ascending and wrapping modulo NUM_CH.
- Scan advance:
  - On each scan capture, if dwell_cnt == DWELL-1: dwell_cnt <= 0; cur_ch <= next set mask bit strictly after target (wrapping).
  - Otherwise dwell_cnt <= dwell_cnt+1.
  - If the advance index is <= target (wrapped, including the single-enabled-channel case), wrap_pend <= 1.
- wrap <= 1 on the capture cycle where wrap_pend=1, and wrap_pend clears; wrap=0 on every other cycle. The first pass after reset does not assert wrap.
- Mode change (mode differs from its registered previous value): dwell_cnt <= 0 and wrap_pend <= 0; cur_ch is kept. A capture in the same cycle uses the new mode.
- Manual mode does not modify cur_ch.
- ch_mask changes take effect on the next target computation. A now-masked cur_ch is skipped without a capture on it.

Decomposition:
- Package mux_scan_pkg:
  - MODE_MANUAL=1'b0, MODE_SCAN=1'b1.
  - Function next_set_idx(mask, start, inclusive) returning index and wrapped flag.
- Optional combinational sub-module rr_next_en: rotating priority finder over ch_mask. Used twice, once for target (inclusive) and once for advance (exclusive).
- Top module holds the registers, handshake and dwell/wrap logic.

Test Plan:
All scenarios use NUM_CH=8, DATA_W=4, DWELL=2 unless stated.
1. Manual: mode=0, sel_in=5, din ch5=4'hA, en=1, dout_ready=1 -> next cycle dout=4'hA, dout_ch=5, dout_valid=1. Then sel_in=9 with NUM_CH=12 build, en=1 -> valid sample of ch9. With sel_in=3'd7 and NUM_CH=6 (SEL_W=3) -> no capture, dout_valid=0 after accept.
2. Full scan: mode=1, ch_mask=8'hFF, en=1, ready=1 -> dout_ch sequence 0,0,1,1,...,7,7,0,0. wrap=1 only with the 17th sample (dout_ch=0); wrap=0 at start.
3. Sparse mask: ch_mask=8'b1010_0100 -> dout_ch sequence 2,2,5,5,7,7,2; wrap=1 with the 7th sample.
4. Backpressure: during scan, dout_ready=0 for 3 cycles -> dout, dout_ch, dout_valid unchanged. Dwell does not advance; the sequence resumes exactly where it stopped after ready=1.
5. Empty mask / disable: ch_mask=0 or en=0 with ready=1 -> dout_valid drops next cycle and dout holds its last value. Restoring ch_mask=8'h10 -> samples from ch4 with wrap on every pass after the first.
6. Reset mid-stall: dout_valid=1, ready=0, assert rst between clock edges -> all outputs 0 immediately. After release, scan restarts at ch0 with no wrap.
